arbiter_rr16: RTL and testbench
===============================

ARBITER_RR16 -- requirements
Module: arbiter_rr16

Interface
REQ-001 SHALL have parameter: MAX_HOLD, default 16, maximum cycles one grant may be held before forced release (legal range 2..255).
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high; one clock, no other reset.
REQ-004 SHALL have port: enable  input  1  high permits new grants; low blocks new grants only.
REQ-005 SHALL have port: req  input  16  request vector, bit i = requester i.
REQ-006 SHALL have port: done  input  1  granted requester finished; releases the current grant.
REQ-007 SHALL have port: grant_onehot  output  16  registered one-hot grant; all-zero when no grant.
REQ-008 SHALL have port: grant_idx  output  4  registered binary index of the granted requester.
REQ-009 SHALL have port: grant_valid  output  1  high while a grant is active.
REQ-010 SHALL have port: timeout  output  1  one-cycle pulse on forced release.

Function
REQ-011 SHALL implement FSM states IDLE, GRANT, RELEASE; encoding is free.
REQ-012 SHALL, in IDLE with enable=1 and req!=0, select the winner and enter GRANT; outputs update on that same clock edge (request sampled at edge N -> grant visible after edge N).
REQ-013 SHALL select round-robin: search starts at index (last_idx+1) mod 16, ascending with wrap from 15 to 0; first set req bit wins.
REQ-014 SHALL update last_idx to the winner index on every grant.
REQ-015 SHALL keep grant_onehot, grant_idx, grant_valid constant throughout GRANT.
REQ-016 SHALL keep grant_onehot == (1 << grant_idx) whenever grant_valid=1, and grant_onehot=0 whenever grant_valid=0.
REQ-017 SHALL leave GRANT for RELEASE when done=1, or when req[grant_idx]=0, or when the hold count reaches MAX_HOLD.
REQ-018 SHALL count hold cycles from 1 on the first GRANT cycle; at count MAX_HOLD with done=0 and req[grant_idx]=1, SHALL force release and pulse timeout for exactly one cycle coincident with the first RELEASE cycle.
REQ-019 SHALL treat done=1 at count MAX_HOLD as a normal release (timeout stays 0).
REQ-020 SHALL spend exactly one cycle in RELEASE with grant_valid=0, then go to IDLE; minimum gap between consecutive grants is two cycles (RELEASE and IDLE).
REQ-021 SHALL ignore done while in IDLE or RELEASE.
REQ-022 SHALL, with enable=0, stay in IDLE; enable falling during GRANT SHALL NOT shorten the current grant.
REQ-023 SHALL ignore req changes on non-granted bits during GRANT; they are evaluated at next IDLE.
REQ-024 SHALL size the hold counter to hold MAX_HOLD without wrap.

Reset
REQ-025 SHALL on rst=1 at a clock edge force: state IDLE, grant_onehot=0, grant_idx=0, grant_valid=0, timeout=0, hold count 0, last_idx=15 (first search starts at 0).
REQ-026 SHALL let rst override every other input, including mid-GRANT; no grant SHALL be issued on the edge where rst=1.
REQ-027 SHALL issue the first possible grant on the first edge after rst deasserts.

Verification
REQ-028 SHALL cover: after reset, req=16'h8001, enable=1 -> grant_idx=0, grant_onehot=16'h0001 one cycle later; done pulse -> next grant grant_idx=15, grant_onehot=16'h8000.
REQ-029 SHALL cover: req=16'hFFFF held, done pulsed each grant -> grant_idx sequence 0,1,...,15,0 with exactly two non-grant cycles between grants.
REQ-030 SHALL cover: MAX_HOLD=4, req=16'h0010 held, done=0 -> grant_valid high 4 cycles, then timeout=1 for one cycle with grant_valid=0, regrant of idx 4 two cycles after release.
REQ-031 SHALL cover: granted idx 3 drops req[3] without done -> grant_valid=0 next cycle, timeout=0.
REQ-032 SHALL cover: enable=0 with req=16'h0F00 -> no grant for 10 cycles; enable=1 -> grant_idx=8 next cycle; enable=0 mid-grant -> grant persists until done.
REQ-033 SHALL cover: rst=1 asserted during GRANT of idx 7 -> all outputs zero next cycle; after release of rst with req=16'h0080 -> grant_idx=7 (search restarted from 0).

Source files
------------

// File: rtl/arbiter_rr16.sv
// -----------------------------------------------------------------------------
// arbiter_rr16 : 16-way round-robin arbiter with bounded grant hold time.
//
// A single grant is issued at a time. The winner is the first set request bit
// found scanning upward (with wrap) from the index just after the previous
// winner. A grant ends when the holder signals done, drops its request, or
// has held the grant for MAX_HOLD cycles (forced release, flagged by timeout).
// Every grant is followed by one RELEASE cycle and one IDLE cycle.
//
// Ports
//   clk           in   1   rising-edge clock
//   rst           in   1   synchronous active-high reset
//   enable        in   1   permits new grants (does not cut an active grant)
//   req           in  16   request vector, bit i = requester i
//   done          in   1   current holder finished
//   grant_onehot  out 16   registered one-hot grant, zero when no grant
//   grant_idx     out  4   registered index of the granted requester
//   grant_valid   out  1   grant active
//   timeout       out  1   one-cycle pulse on forced release
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no grant; arbitrate when enable=1 and any request present
// GRANT   | grant held; count hold cycles, watch done / req / limit
// RELEASE | one dead cycle after a grant, outputs cleared
// -----------------------------------------------------------------------------
module arbiter_rr16 #(
  parameter int MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] grant_onehot,
  output logic [3:0]  grant_idx,
  output logic        grant_valid,
  output logic        timeout
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RELEASE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_hold, w_hold_nxt;
  logic [3:0]    r_last_idx, w_last_idx_nxt;
  logic [15:0]   r_grant_onehot, w_grant_onehot_nxt;
  logic [3:0]    r_grant_idx, w_grant_idx_nxt;
  logic          r_grant_valid, w_grant_valid_nxt;
  logic          r_timeout, w_timeout_nxt;

  logic          w_found;
  logic [3:0]    w_win;
  logic          w_hold_full;
  logic          w_holder_req;

  // Rotating priority search: candidates last+1, last+2, ... last+16 (mod 16);
  // 4-bit addition supplies the wrap from 15 to 0.
  always_comb begin : rr_search
    logic [3:0] cand;
    w_found = 1'b0;
    w_win   = r_last_idx;
    cand    = r_last_idx;
    for (int k = 1; k <= 16; k++) begin
      cand = r_last_idx + 4'(k);
      if (!w_found && req[cand]) begin
        w_found = 1'b1;
        w_win   = cand;
      end
    end
  end

  assign w_hold_full  = (r_hold == HOLD_MAX);
  assign w_holder_req = req[r_grant_idx];

  always_comb begin
    w_state_nxt        = r_state;
    w_hold_nxt         = r_hold;
    w_last_idx_nxt     = r_last_idx;
    w_grant_onehot_nxt = r_grant_onehot;
    w_grant_idx_nxt    = r_grant_idx;
    w_grant_valid_nxt  = r_grant_valid;
    w_timeout_nxt      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (enable && w_found) begin
          w_state_nxt        = S_GRANT;
          w_grant_valid_nxt  = 1'b1;
          w_grant_idx_nxt    = w_win;
          w_grant_onehot_nxt = 16'd1 << w_win;
          w_last_idx_nxt     = w_win;
          w_hold_nxt         = CW'(1);
        end
      end

      S_GRANT: begin
        if (done || !w_holder_req || w_hold_full) begin
          w_state_nxt        = S_RELEASE;
          w_grant_valid_nxt  = 1'b0;
          w_grant_onehot_nxt = '0;
          w_hold_nxt         = '0;
          // Only a release caused purely by the hold limit counts as timeout.
          w_timeout_nxt      = w_hold_full && !done && w_holder_req;
        end else begin
          w_hold_nxt = r_hold + CW'(1);
        end
      end

      S_RELEASE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt        = S_IDLE;
        w_grant_valid_nxt  = 1'b0;
        w_grant_onehot_nxt = '0;
        w_hold_nxt         = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_hold         <= '0;
      r_last_idx     <= 4'hF;
      r_grant_onehot <= '0;
      r_grant_idx    <= '0;
      r_grant_valid  <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_hold         <= w_hold_nxt;
      r_last_idx     <= w_last_idx_nxt;
      r_grant_onehot <= w_grant_onehot_nxt;
      r_grant_idx    <= w_grant_idx_nxt;
      r_grant_valid  <= w_grant_valid_nxt;
      r_timeout      <= w_timeout_nxt;
    end
  end

  assign grant_onehot = r_grant_onehot;
  assign grant_idx    = r_grant_idx;
  assign grant_valid  = r_grant_valid;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_arbiter_rr16.sv
// Bench for arbiter_rr16 with a short hold limit so forced releases are easy
// to reach. Directed rows, two hand-written sequences, then random traffic
// compared against a reference model.
module tb_arbiter_rr16;

  localparam int MH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] req;
  logic        done;
  logic [15:0] grant_onehot;
  logic [3:0]  grant_idx;
  logic        grant_valid;
  logic        timeout;

  int n_vec = 0;
  int n_err = 0;

  arbiter_rr16 #(.MAX_HOLD(MH)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .req          (req),
    .done         (done),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .grant_valid  (grant_valid),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the grant (-1 = nobody), how long they have
  // held it, and how many further edges must pass before a new grant.
  int m_owner     = -1;
  int m_hold      = 0;
  int m_cool      = 0;
  int m_last      = 15;
  bit m_to        = 1'b0;
  bit m_after_rst = 1'b0;

  function automatic void model_step();
    m_to = 1'b0;
    if (rst) begin
      m_owner     = -1;
      m_hold      = 0;
      m_cool      = 0;
      m_last      = 15;
      m_after_rst = 1'b1;
      return;
    end
    m_after_rst = 1'b0;
    if (m_owner >= 0) begin
      if (done || !req[m_owner] || m_hold == MH) begin
        m_to    = !done && req[m_owner] && (m_hold == MH);
        m_owner = -1;
        m_cool  = 1;
      end else begin
        m_hold++;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (enable && req != 16'd0) begin
      for (int k = 1; k <= 16; k++) begin
        int j;
        j = (m_last + k) % 16;
        if (req[j]) begin
          m_owner = j;
          break;
        end
      end
      m_last = m_owner;
      m_hold = 1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic [15:0] req;
    logic        done;
    logic        ev;
    logic [3:0]  ei;
    logic        ci;
    logic        eto;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic e, logic [15:0] q, logic d,
                              logic ev, logic [3:0] ei, logic ci, logic eto);
    vec_t v;
    v.rst = r; v.en = e; v.req = q; v.done = d;
    v.ev = ev; v.ei = ei; v.ci = ci; v.eto = eto;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; req = '0; done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int gap;
    rst = 1'b1; enable = 1'b0; req = '0; done = 1'b0;
    #2;

    //              rst en  req       done  ev  ei  ci  eto
    tbl.push_back(mk(1, 0, 16'h0000, 0,    0, 0,  1,  0)); // reset state
    tbl.push_back(mk(0, 1, 16'h8001, 0,    1, 0,  1,  0)); // first grant idx 0
    tbl.push_back(mk(0, 1, 16'h8001, 1,    0, 0,  0,  0)); // done -> RELEASE
    tbl.push_back(mk(0, 1, 16'h8001, 0,    0, 0,  0,  0)); // IDLE
    tbl.push_back(mk(0, 1, 16'h8001, 0,    1, 15, 1,  0)); // round robin -> 15
    tbl.push_back(mk(0, 1, 16'h8001, 1,    0, 0,  0,  0));
    tbl.push_back(mk(0, 1, 16'h0008, 0,    0, 0,  0,  0));
    tbl.push_back(mk(0, 1, 16'h0008, 0,    1, 3,  1,  0)); // grant idx 3
    tbl.push_back(mk(0, 1, 16'h0000, 0,    0, 0,  0,  0)); // req drop, no timeout
    tbl.push_back(mk(0, 1, 16'h0080, 0,    0, 0,  0,  0));
    tbl.push_back(mk(0, 1, 16'h0080, 0,    1, 7,  1,  0)); // grant idx 7
    tbl.push_back(mk(0, 1, 16'h0080, 0,    1, 7,  1,  0));
    tbl.push_back(mk(1, 1, 16'h0080, 0,    0, 0,  1,  0)); // reset mid-grant
    tbl.push_back(mk(0, 1, 16'h0180, 0,    1, 7,  1,  0)); // search from 0 again
    tbl.push_back(mk(0, 1, 16'h0180, 1,    0, 0,  0,  0));
    tbl.push_back(mk(0, 1, 16'h0010, 0,    0, 0,  0,  0));
    tbl.push_back(mk(0, 1, 16'h0010, 0,    1, 4,  1,  0)); // hold 1
    tbl.push_back(mk(0, 1, 16'h0010, 0,    1, 4,  1,  0)); // hold 2
    tbl.push_back(mk(0, 1, 16'h0010, 0,    1, 4,  1,  0)); // hold 3
    tbl.push_back(mk(0, 1, 16'h0010, 0,    1, 4,  1,  0)); // hold 4
    tbl.push_back(mk(0, 1, 16'h0010, 0,    0, 0,  0,  1)); // forced release
    tbl.push_back(mk(0, 1, 16'h0010, 0,    0, 0,  0,  0)); // IDLE
    tbl.push_back(mk(0, 1, 16'h0010, 0,    1, 4,  1,  0)); // regrant, hold 1
    tbl.push_back(mk(0, 1, 16'h0010, 0,    1, 4,  1,  0)); // hold 2
    tbl.push_back(mk(0, 1, 16'h0010, 0,    1, 4,  1,  0)); // hold 3
    tbl.push_back(mk(0, 1, 16'h0010, 0,    1, 4,  1,  0)); // hold 4
    tbl.push_back(mk(0, 1, 16'h0010, 1,    0, 0,  0,  0)); // done at limit
    tbl.push_back(mk(0, 1, 16'h0010, 0,    0, 0,  0,  0));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; enable = tbl[i].en; req = tbl[i].req; done = tbl[i].done;
      tick();
      chk($sformatf("row%0d valid", i), 16'(grant_valid), 16'(tbl[i].ev));
      chk($sformatf("row%0d onehot", i), grant_onehot,
          tbl[i].ev ? (16'd1 << tbl[i].ei) : 16'd0);
      chk($sformatf("row%0d timeout", i), 16'(timeout), 16'(tbl[i].eto));
      if (tbl[i].ci)
        chk($sformatf("row%0d idx", i), 16'(grant_idx), 16'(tbl[i].ei));
    end

    // All requesters active: indices rotate 0..15,0 with two dead cycles.
    do_reset();
    enable = 1'b1; req = 16'hFFFF; done = 1'b0;
    gap = 0;
    for (int g = 0; g <= 16; g++) begin
      tick();
      while (!grant_valid && gap < 6) begin
        gap++;
        tick();
      end
      chk($sformatf("rot%0d valid", g), 16'(grant_valid), 16'd1);
      chk($sformatf("rot%0d idx", g), 16'(grant_idx), 16'(g % 16));
      if (g > 0) chk($sformatf("rot%0d gap", g), 16'(gap), 16'd2);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk($sformatf("rot%0d release", g), 16'(grant_valid), 16'd0);
      gap = 1;
    end

    // enable low blocks new grants but does not cut an active one.
    do_reset();
    enable = 1'b0; req = 16'h0F00;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("en_off%0d valid", c), 16'(grant_valid), 16'd0);
    end
    enable = 1'b1;
    tick();
    chk("en_on valid", 16'(grant_valid), 16'd1);
    chk("en_on idx", 16'(grant_idx), 16'd8);
    enable = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("en_drop%0d valid", c), 16'(grant_valid), 16'd1);
      chk($sformatf("en_drop%0d idx", c), 16'(grant_idx), 16'd8);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("en_done valid", 16'(grant_valid), 16'd0);
    chk("en_done timeout", 16'(timeout), 16'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("en_idle%0d valid", c), 16'(grant_valid), 16'd0);
    end

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst    = ($urandom_range(63) == 0);
      enable = ($urandom_range(3) != 0);
      done   = ($urandom_range(3) == 0);
      if ($urandom_range(3) == 0)
        req = 16'($urandom) & 16'($urandom) & 16'($urandom);
      tick();
      chk("rnd valid", 16'(grant_valid), 16'(m_owner >= 0));
      chk("rnd onehot", grant_onehot, (m_owner >= 0) ? (16'd1 << m_owner) : 16'd0);
      chk("rnd timeout", 16'(timeout), 16'(m_to));
      if (m_owner >= 0) chk("rnd idx", 16'(grant_idx), 16'(m_owner));
      else if (m_after_rst) chk("rnd idx after rst", 16'(grant_idx), 16'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
